// File: rtl/dlf_cvt_sched.sv
// dlf_cvt_sched: round-robin share of one int32->DLFloat16 converter; grant/issue same cycle, response >= CVT_LAT+1 later.
// Credits cover in-flight + buffered results so rsp backpressure never loses data; DLF_INEXACT_EN adds an issue-time inexact flag.
module dlf_cvt_sched #(
  parameter int NUM_REQ   = 4,
  parameter int CVT_LAT   = 1,
  parameter int RSP_DEPTH = 4,
  parameter int IDW       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  cvt_valid,
  output logic [31:0]           cvt_in,
  input  logic [15:0]           cvt_out,
  input  logic [4:0]            cvt_exc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           rsp_data,
  output logic [4:0]            rsp_exc,
  output logic                  busy
);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CRED = CW'(RSP_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, STALL, DRAIN} state_t;
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    dat;
    logic [4:0]     exc;
  } rsp_ent_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      credits_q, credits_d;
  logic [CVT_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]     tag_id_q [CVT_LAT];
  logic [IDW-1:0]     tag_id_d [CVT_LAT];
  rsp_ent_t           mem_q [RSP_DEPTH];
  rsp_ent_t           mem_d [RSP_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
`ifdef DLF_INEXACT_EN
  logic [CVT_LAT-1:0] tag_inx_q, tag_inx_d;
  logic [31:0]        op_abs;
  logic               inexact;
`endif

  logic           any_req, found, issue, push, pop, all_empty;
  logic [IDW-1:0] winner, idx;
  logic [31:0]    win_dat;
  int             sel_idx;
  rsp_ent_t       push_ent;

  // First requesting port at or after rr_ptr, wrapping.
  always_comb begin
    any_req = |req_valid;
    found   = 1'b0;
    winner  = '0;
    sel_idx = 0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      idx     = IDW'(sel_idx);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    win_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) win_dat = req_data[32*i +: 32];
    end
  end

  // rst_n is an active-high reset here; grants are held off while it is asserted.
  always_comb begin
    issue     = !rst_n && en && (credits_q != '0) && any_req;
    req_ready = issue ? (NUM_REQ'(1) << winner) : '0;
    cvt_valid = issue;
    cvt_in    = issue ? win_dat : '0;
    rr_ptr_d  = rr_ptr_q;
    if (issue) rr_ptr_d = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
  end

`ifdef DLF_INEXACT_EN
  // A bit is lost if some 1 sits at least 10 places above it; -2^31 negates to 2^31 as unsigned.
  always_comb begin
    op_abs  = win_dat[31] ? (~win_dat + 32'd1) : win_dat;
    inexact = 1'b0;
    for (int i = 0; i < 22; i++) inexact = inexact | (op_abs[i] & (|(op_abs >> (i + 10))));
  end
`endif

  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = issue;
    tag_id_d[0]  = winner;
    for (int k = 1; k < CVT_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
`ifdef DLF_INEXACT_EN
    tag_inx_d    = '0;
    tag_inx_d[0] = issue & inexact;
    for (int k = 1; k < CVT_LAT; k++) tag_inx_d[k] = tag_inx_q[k-1];
`endif
  end

  always_comb begin
    push         = tag_vld_q[CVT_LAT-1];
    push_ent.id  = tag_id_q[CVT_LAT-1];
    push_ent.dat = cvt_out;
`ifdef DLF_INEXACT_EN
    push_ent.exc = {cvt_exc[4:1], cvt_exc[0] | tag_inx_q[CVT_LAT-1]};
`else
    push_ent.exc = cvt_exc;
`endif
    rsp_valid = (count_q != '0);
    pop       = rsp_valid & rsp_ready;
    rsp_id    = rsp_valid ? mem_q[rd_ptr_q].id  : '0;
    rsp_data  = rsp_valid ? mem_q[rd_ptr_q].dat : '0;
    rsp_exc   = rsp_valid ? mem_q[rd_ptr_q].exc : '0;
    mem_d     = mem_q;
    if (push) mem_d[wr_ptr_q] = push_ent;
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    credits_d = credits_q - CW'(issue) + CW'(pop);
    all_empty = (credits_q == FULL_CRED);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      credits_q <= FULL_CRED;
      tag_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int k = 0; k < CVT_LAT; k++) tag_id_q[k] <= '0;
      for (int d = 0; d < RSP_DEPTH; d++) mem_q[d] <= '0;
`ifdef DLF_INEXACT_EN
      tag_inx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
`ifdef DLF_INEXACT_EN
      tag_inx_q <= tag_inx_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = ACTIVE;
      ACTIVE: begin
        if (!en)                                 state_d = DRAIN;
        else if ((credits_q == '0) && any_req)   state_d = STALL;
        else if (!any_req && all_empty)          state_d = IDLE;
      end
      STALL: begin
        if (!en)                   state_d = DRAIN;
        else if (credits_q != '0)  state_d = ACTIVE;
      end
      DRAIN: begin
        if (en)             state_d = ACTIVE;
        else if (all_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end
endmodule

// File: tb/tb_dlf_cvt_sched.sv
// Bench for dlf_cvt_sched: directed scenarios plus random traffic checked against a queue-based reference.
module tb_dlf_cvt_sched;
  localparam int NUM_REQ = 4, CVT_LAT = 1, RSP_DEPTH = 4, IDW = 2;
`ifdef DLF_INEXACT_EN
  localparam bit INX_EN = 1'b1;
`else
  localparam bit INX_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, rsp_ready = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [32*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  cvt_valid, rsp_valid, busy;
  logic [31:0]           cvt_in;
  logic [15:0]           cvt_out, rsp_data;
  logic [4:0]            cvt_exc, rsp_exc;
  logic [IDW-1:0]        rsp_id;

  dlf_cvt_sched #(.NUM_REQ(NUM_REQ), .CVT_LAT(CVT_LAT), .RSP_DEPTH(RSP_DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cvt_valid(cvt_valid), .cvt_in(cvt_in), .cvt_out(cvt_out),
    .cvt_exc(cvt_exc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_exc(rsp_exc), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference int32 -> DLFloat16 by magnitude/exponent arithmetic, truncating.
  function automatic logic [15:0] dlf(input logic [31:0] op);
    longint a, m;
    int p;
    a = op[31] ? (64'd4294967296 - longint'(op)) : longint'(op);
    if (a == 0) return 16'h0000;
    p = 0;
    while ((a >> (p + 1)) != 0) p++;
    m = (p >= 9) ? a / (64'd1 << (p - 9)) : a * (64'd1 << (9 - p));
    return {op[31], 6'(p + 31), 9'(m % 512)};
  endfunction

  function automatic bit lossy(input logic [31:0] op);
    longint a;
    int p;
    a = op[31] ? (64'd4294967296 - longint'(op)) : longint'(op);
    if (a == 0) return 1'b0;
    p = 0;
    while ((a >> (p + 1)) != 0) p++;
    return (p > 9) && ((a % (64'd1 << (p - 9))) != 0);
  endfunction

  function automatic logic [4:0] cvt_flags(input logic [31:0] op);
    return {op[3:0], op[7:4] == 4'hF};
  endfunction

  function automatic logic [4:0] exp_flags(input logic [31:0] op);
    logic [4:0] f;
    f = cvt_flags(op);
    f[0] = f[0] | (INX_EN & lossy(op));
    return f;
  endfunction

  // Converter stand-in: fixed CVT_LAT pipeline, garbage when not carrying a result.
  logic        cv_v [CVT_LAT];
  logic [15:0] cv_d [CVT_LAT];
  logic [4:0]  cv_e [CVT_LAT];
  always @(posedge clk) begin
    cv_v[0] <= cvt_valid;
    cv_d[0] <= dlf(cvt_in);
    cv_e[0] <= cvt_flags(cvt_in);
    for (int k = 1; k < CVT_LAT; k++) begin
      cv_v[k] <= cv_v[k-1];
      cv_d[k] <= cv_d[k-1];
      cv_e[k] <= cv_e[k-1];
    end
  end
  assign cvt_out = cv_v[CVT_LAT-1] ? cv_d[CVT_LAT-1] : 16'hDEAD;
  assign cvt_exc = cv_v[CVT_LAT-1] ? cv_e[CVT_LAT-1] : 5'h1F;

  // Reference: outstanding results in issue order, each visible from its ready cycle on.
  typedef struct {
    int         id;
    logic [15:0] d;
    logic [4:0]  e;
    int         rdy;
  } exp_t;
  exp_t exp_q[$];
  int   m_rr = 0, m_w, m_r, m_cred;
  bit   m_gnt, m_head;
  logic [31:0] m_op;

  always @(negedge clk) begin
    if (mon_en) begin
      m_cred = RSP_DEPTH - exp_q.size();
      m_gnt  = 1'b0;
      m_w    = 0;
      if (!rst_n && en && m_cred > 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          m_r = (m_rr + k) % NUM_REQ;
          if (!m_gnt && req_valid[m_r]) begin
            m_gnt = 1'b1;
            m_w   = m_r;
          end
        end
      end
      check("req_ready", req_ready, m_gnt ? (32'd1 << m_w) : 32'd0);
      check("cvt_valid", cvt_valid, m_gnt);
      m_op = req_data[32*m_w +: 32];
      if (m_gnt) check("cvt_in", cvt_in, m_op);
      m_head = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
      check("rsp_valid", rsp_valid, m_head);
      if (m_head && rsp_valid) begin
        check("rsp_id", rsp_id, exp_q[0].id);
        check("rsp_data", rsp_data, exp_q[0].d);
        check("rsp_exc", rsp_exc, exp_q[0].e);
      end
      if (rst_n) begin
        exp_q.delete();
        m_rr = 0;
      end else begin
        if (m_head && rsp_ready) void'(exp_q.pop_front());
        if (m_gnt) begin
          exp_q.push_back('{id: m_w, d: dlf(m_op), e: exp_flags(m_op), rdy: cyc + CVT_LAT + 1});
          m_rr = (m_w + 1) % NUM_REQ;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h8000_0000;
      2: v = 32'd1024;
      3: v = 32'd1025;
      4: v = 32'($urandom_range(0, 2047));
      5: v = -32'($urandom_range(1, 2047));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic single(input int r, input logic [31:0] op, input logic [15:0] exp_d, input string tag);
    int lat;
    step();
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_data[32*r +: 32] = op;
    @(negedge clk);
    check({tag, "_gnt"}, req_ready, 32'd1 << r);
    step();
    req_valid = '0;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) lat = k;
    end
    check({tag, "_lat"}, lat, CVT_LAT + 1);
    check({tag, "_id"}, rsp_id, r);
    check({tag, "_dat"}, rsp_data, exp_d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ng, np;
    logic [NUM_REQ-1:0] g;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_data", rsp_data, 0);

    en = 1'b1;
    rsp_ready = 1'b1;
    single(0, 32'd5, 16'h4280, "t1");
    single(2, 32'hFFFF_FFFF, 16'hBE00, "t2");
    single(3, 32'd1025, 16'h5200, "inx1025");
    check("inx1025_exc0", rsp_exc[0], INX_EN);
    single(3, 32'd1024, 16'h5200, "inx1024");
    check("inx1024_exc0", rsp_exc[0], 0);

    // fairness: rr_ptr is back at 0 after a grant to port 3
    step();
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = rand_op();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fair_gnt", req_ready, 32'd1 << (k % NUM_REQ));
    end
    step();
    req_valid = '0;
    repeat (6) @(negedge clk);

    // backpressure
    step();
    rsp_ready = 1'b0;
    req_valid = '1;
    ng = 0;
    repeat (10) begin
      @(negedge clk);
      ng += $countones(req_valid & req_ready);
    end
    check("bp_grants", ng, RSP_DEPTH);
    check("bp_ready", req_ready, 0);
    check("bp_busy", busy, 1);
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_cycle", req_ready, 0);
    @(negedge clk);
    check("bp_resume", req_ready, 4'b0001);
    repeat (6) @(negedge clk);
    step();
    req_valid = '0;
    repeat (12) @(negedge clk);

    // drain with two ops in flight
    step();
    req_valid = '1;
    repeat (2) @(negedge clk);
    step();
    en = 1'b0;
    ng = 0;
    np = 0;
    repeat (8) begin
      @(negedge clk);
      ng += $countones(req_valid & req_ready);
      np += int'(rsp_valid & rsp_ready);
    end
    check("drain_grants", ng, 0);
    check("drain_rsps", np, 2);
    check("drain_busy", busy, 0);
    step();
    req_valid = '0;
    en = 1'b1;

    // reset with three buffered results
    rsp_ready = 1'b0;
    step();
    req_valid = '1;
    repeat (3) @(negedge clk);
    step();
    req_valid = '0;
    repeat (4) @(negedge clk);
    check("rm_pre_valid", rsp_valid, 1);
    step();
    rst_n = 1'b1;
    req_valid = 4'b0110;
    @(negedge clk);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("rm_rsp_valid", rsp_valid, 0);
    check("rm_busy", busy, 0);
    check("rm_first_gnt", req_ready, 4'b0010);
    ng = $countones(req_valid & req_ready);
    repeat (7) begin
      @(negedge clk);
      ng += $countones(req_valid & req_ready);
    end
    check("rm_credits", ng, RSP_DEPTH);
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);

    // random traffic with enable/backpressure toggling and occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      step();
      rst_n = (c % 700 == 350);
      en = ($urandom_range(0, 99) < 90);
      rsp_ready = ($urandom_range(0, 99) < 70);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 55);
          req_data[32*i +: 32] = rand_op();
        end
      end
    end

    step();
    rst_n = 1'b0;
    req_valid = '0;
    en = 1'b1;
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("final_busy", busy, 0);
    check("final_rsp_valid", rsp_valid, 0);
    check("final_outstanding", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
